// File: rtl/ysyx_23060124_exu_wbu_stage.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060124_exu_wbu_stage
// Brief   : Handshaked EXU->WBU stage (1-entry register or 2-entry skid
//           buffer) carrying the writeback payload and the registered redirect.
//           Optional perf counters enabled by `define EXU_WBU_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_23060124_exu_wbu_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_pc_next,
  input  logic [XLEN-1:0]   i_res,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic              i_wen,
  input  logic [CSR_AW-1:0] i_csr_addr,
  input  logic              i_csr_wen,
  input  logic              i_brch,
  input  logic              i_jal,
  input  logic              i_jalr,
  input  logic              i_mret,
  input  logic              i_ecall,
  input  logic [XLEN-1:0]   i_mepc,
  input  logic [XLEN-1:0]   i_mtvec,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_pc_next,
  output logic [XLEN-1:0]   o_res,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic              o_wen,
  output logic [CSR_AW-1:0] o_csr_addr,
  output logic              o_csr_wen,
  output logic              o_redirect,
  output logic [XLEN-1:0]   o_redirect_pc,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   res;
    logic [REG_AW-1:0] rd_addr;
    logic              wen;
    logic [CSR_AW-1:0] csr_addr;
    logic              csr_wen;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
  } entry_t;

  entry_t w_in_entry;
  entry_t r_head;
  logic   r_head_valid;
  logic   w_accept;
  logic   w_drain;

  // Redirect is resolved at capture so the head presents it with no extra logic.
  always_comb begin
    w_in_entry             = '0;
    w_in_entry.pc_next     = i_pc_next;
    w_in_entry.res         = i_res;
    w_in_entry.rd_addr     = i_rd_addr;
    w_in_entry.wen         = i_wen;
    w_in_entry.csr_addr    = i_csr_addr;
    w_in_entry.csr_wen     = i_csr_wen;
    if (i_ecall) begin
      w_in_entry.redirect    = 1'b1;
      w_in_entry.redirect_pc = i_mtvec;
    end else if (i_mret) begin
      w_in_entry.redirect    = 1'b1;
      w_in_entry.redirect_pc = i_mepc;
    end else if (i_jal || i_jalr || (i_brch && i_res[0])) begin
      w_in_entry.redirect    = 1'b1;
      w_in_entry.redirect_pc = i_pc_next;
    end
  end

  assign w_accept = i_valid && o_ready;
  assign w_drain  = r_head_valid && i_ready;

  generate
    if (DEPTH == 1) begin : g_single
      assign o_ready = !r_head_valid || i_ready;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_head_valid <= 1'b0;
          r_head       <= '0;
        end else if (i_flush) begin
          r_head_valid <= 1'b0;
        end else if (w_accept) begin
          r_head       <= w_in_entry;
          r_head_valid <= 1'b1;
        end else if (w_drain) begin
          r_head_valid <= 1'b0;
        end
      end
    end else begin : g_skid
      entry_t r_skid;
      logic   r_skid_valid;

      assign o_ready = !r_skid_valid;

      // Skid is only ever occupied behind a valid head, which keeps order FIFO.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_head_valid <= 1'b0;
          r_skid_valid <= 1'b0;
          r_head       <= '0;
          r_skid       <= '0;
        end else if (i_flush) begin
          r_head_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (!r_head_valid) begin
          if (w_accept) begin
            r_head       <= w_in_entry;
            r_head_valid <= 1'b1;
          end
        end else if (w_drain) begin
          if (r_skid_valid) begin
            r_head       <= r_skid;
            r_skid_valid <= 1'b0;
          end else if (w_accept) begin
            r_head       <= w_in_entry;
          end else begin
            r_head_valid <= 1'b0;
          end
        end else if (w_accept) begin
          r_skid       <= w_in_entry;
          r_skid_valid <= 1'b1;
        end
      end
    end
  endgenerate

  assign o_valid       = r_head_valid;
  assign o_pc_next     = r_head.pc_next;
  assign o_res         = r_head.res;
  assign o_rd_addr     = r_head.rd_addr;
  assign o_wen         = r_head.wen;
  assign o_csr_addr    = r_head.csr_addr;
  assign o_csr_wen     = r_head.csr_wen;
  assign o_redirect    = r_head_valid && r_head.redirect;
  assign o_redirect_pc = r_head.redirect_pc;

`ifdef EXU_WBU_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= 32'h0;
      r_bubble_cnt <= 32'h0;
    end else begin
      if (r_head_valid && !i_ready) r_stall_cnt  <= r_stall_cnt + 32'h1;
      if (!r_head_valid)            r_bubble_cnt <= r_bubble_cnt + 32'h1;
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`else
  assign o_stall_cnt  = 32'h0;
  assign o_bubble_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060124_exu_wbu_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_23060124_exu_wbu_stage
// Brief   : Directed + random bench for the EXU->WBU stage against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_23060124_exu_wbu_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [31:0] i_pc_next = '0, i_res = '0, i_mepc = '0, i_mtvec = '0;
  logic [4:0]  i_rd_addr = '0;
  logic [11:0] i_csr_addr = '0;
  logic        i_wen = 1'b0, i_csr_wen = 1'b0;
  logic        i_brch = 1'b0, i_jal = 1'b0, i_jalr = 1'b0, i_mret = 1'b0, i_ecall = 1'b0;
  logic        o_ready, o_valid, o_wen, o_csr_wen, o_redirect;
  logic [31:0] o_pc_next, o_res, o_redirect_pc, o_stall_cnt, o_bubble_cnt;
  logic [4:0]  o_rd_addr;
  logic [11:0] o_csr_addr;

  ysyx_23060124_exu_wbu_stage #(.XLEN(32), .REG_AW(5), .CSR_AW(12), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc_next(i_pc_next), .i_res(i_res), .i_rd_addr(i_rd_addr), .i_wen(i_wen),
    .i_csr_addr(i_csr_addr), .i_csr_wen(i_csr_wen), .i_brch(i_brch), .i_jal(i_jal),
    .i_jalr(i_jalr), .i_mret(i_mret), .i_ecall(i_ecall), .i_mepc(i_mepc), .i_mtvec(i_mtvec),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc_next(o_pc_next), .o_res(o_res),
    .o_rd_addr(o_rd_addr), .o_wen(o_wen), .o_csr_addr(o_csr_addr), .o_csr_wen(o_csr_wen),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_stall_cnt(o_stall_cnt), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc, res, rpc;
    logic [4:0]  rd;
    logic        wen;
    logic [11:0] ca;
    logic        cw;
    logic        redir;
  } ent_t;

  ent_t        q[$];
  ent_t        shown = '0;
  logic [31:0] m_stall = '0, m_bubble = '0;
  int          n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk_entry();
    ent_t e;
    e = '0;
    e.pc = i_pc_next; e.res = i_res; e.rd = i_rd_addr; e.wen = i_wen;
    e.ca = i_csr_addr; e.cw = i_csr_wen;
    if (i_ecall)                    begin e.redir = 1'b1; e.rpc = i_mtvec;   end
    else if (i_mret)                begin e.redir = 1'b1; e.rpc = i_mepc;    end
    else if (i_jal || i_jalr)       begin e.redir = 1'b1; e.rpc = i_pc_next; end
    else if (i_brch && i_res[0])    begin e.redir = 1'b1; e.rpc = i_pc_next; end
    return e;
  endfunction

  task automatic check_outputs();
    logic v;
    v = (q.size() > 0);
    if (v) shown = q[0];
    check("valid", {63'h0, o_valid}, {63'h0, v});
    check("ready", {63'h0, o_ready}, {63'h0, (q.size() < 2)});
    check("pc_next", {32'h0, o_pc_next}, {32'h0, shown.pc});
    check("res", {32'h0, o_res}, {32'h0, shown.res});
    check("rd_addr", {59'h0, o_rd_addr}, {59'h0, shown.rd});
    check("wen", {63'h0, o_wen}, {63'h0, shown.wen});
    check("csr_addr", {52'h0, o_csr_addr}, {52'h0, shown.ca});
    check("csr_wen", {63'h0, o_csr_wen}, {63'h0, shown.cw});
    check("redirect", {63'h0, o_redirect}, {63'h0, v && shown.redir});
    check("redirect_pc", {32'h0, o_redirect_pc}, {32'h0, shown.rpc});
`ifdef EXU_WBU_PERF_EN
    check("stall_cnt", {32'h0, o_stall_cnt}, {32'h0, m_stall});
    check("bubble_cnt", {32'h0, o_bubble_cnt}, {32'h0, m_bubble});
`else
    check("stall_cnt", {32'h0, o_stall_cnt}, 64'h0);
    check("bubble_cnt", {32'h0, o_bubble_cnt}, 64'h0);
`endif
  endtask

  // One clock: called at a negedge with inputs already driven.
  task automatic step();
    logic acc, deq;
    ent_t e;
    #1;
    check_outputs();
    acc = i_valid && (q.size() < 2);
    deq = (q.size() > 0) && i_ready;
    e   = mk_entry();
    if (q.size() > 0 && !i_ready) m_stall = m_stall + 32'h1;
    if (q.size() == 0)            m_bubble = m_bubble + 32'h1;
    @(posedge clock);
    if (i_flush) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    q.delete(); shown = '0; m_stall = '0; m_bubble = '0;
    #1 check_outputs();
    repeat (2) @(negedge clock);
    check_outputs();
    reset = 1'b0;
  endtask

  task automatic clr_flags();
    i_brch = 0; i_jal = 0; i_jalr = 0; i_mret = 0; i_ecall = 0;
  endtask

  task automatic rand_payload();
    int f;
    i_pc_next = $urandom; i_res = $urandom; i_rd_addr = 5'($urandom);
    i_wen = 1'($urandom); i_csr_addr = 12'($urandom); i_csr_wen = 1'($urandom);
    i_mepc = $urandom; i_mtvec = $urandom;
    clr_flags();
    f = $urandom_range(0, 7);
    case (f)
      1: i_brch = 1; 2: i_jal = 1; 3: i_jalr = 1; 4: i_mret = 1; 5: i_ecall = 1;
      6: {i_brch, i_jal, i_jalr, i_mret, i_ecall} = 5'($urandom);
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clock);
    // Reset with a valid input held
    i_valid = 1; i_ready = 0; rand_payload();
    do_reset();
    check("t1_reset_res", {32'h0, o_res}, 64'h0);
    i_res = 32'h1234; i_rd_addr = 5; i_wen = 1; clr_flags();
    step();
    i_valid = 0;
    check("t1_valid", {63'h0, o_valid}, 64'h1);
    check("t1_res", {32'h0, o_res}, 64'h1234);
    check("t1_rd", {59'h0, o_rd_addr}, 64'h5);
    i_ready = 1; step();

    // Backpressure: A, B fill head+skid, C blocked
    i_ready = 0; i_valid = 1; clr_flags();
    i_res = 32'hA; step();
    i_res = 32'hB; step();
    i_res = 32'hC;
    check("t2_ready_at_c", {63'h0, o_ready}, 64'h0);
    step();
    i_ready = 1;
    check("t2_first", {32'h0, o_res}, 64'hA); step();
    check("t2_second", {32'h0, o_res}, 64'hB); step();
    i_valid = 0;
    check("t2_third", {32'h0, o_res}, 64'hC); step();
    step();

    // Branch redirect
    i_valid = 1; i_brch = 1; i_res = 32'h1; i_pc_next = 32'h8000_0010; step();
    check("t3_redir", {63'h0, o_redirect}, 64'h1);
    check("t3_rpc", {32'h0, o_redirect_pc}, 64'h8000_0010);
    i_res = 32'h0; step();
    check("t3_not_taken", {63'h0, o_redirect}, 64'h0);

    // ecall / mret targets
    clr_flags(); i_ecall = 1; i_mtvec = 32'h8000_0100; i_mepc = 32'h8000_0020; step();
    check("t4_ecall_rpc", {32'h0, o_redirect_pc}, 64'h8000_0100);
    clr_flags(); i_mret = 1; step();
    check("t4_mret_rpc", {32'h0, o_redirect_pc}, 64'h8000_0020);
    clr_flags(); i_valid = 0; step();

    // Flush with full buffer and a valid input
    i_ready = 0; i_valid = 1; rand_payload(); step(); rand_payload(); step();
    i_flush = 1; rand_payload(); step();
    i_flush = 0; i_valid = 0;
    check("t5_valid", {63'h0, o_valid}, 64'h0);
    check("t5_ready", {63'h0, o_ready}, 64'h1);
    i_ready = 1;
    repeat (3) step();

    // Perf counters: 4 empty + 3 stalled cycles after reset
    i_valid = 0; i_ready = 0;
    do_reset();
    repeat (3) step();
    i_valid = 1; rand_payload(); step();
    i_valid = 0;
    repeat (3) step();
    #1;
`ifdef EXU_WBU_PERF_EN
    check("t6_stall", {32'h0, o_stall_cnt}, 64'd3);
    check("t6_bubble", {32'h0, o_bubble_cnt}, 64'd4);
`else
    check("t6_stall", {32'h0, o_stall_cnt}, 64'd0);
    check("t6_bubble", {32'h0, o_bubble_cnt}, 64'd0);
`endif
    @(negedge clock);

    // Random traffic with occasional flush and asynchronous reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_ready = ($urandom_range(0, 2) != 0);
        i_flush = ($urandom_range(0, 39) == 0);
        rand_payload();
        step();
      end
    end
    i_flush = 0; i_valid = 0; i_ready = 1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
